// File: rtl/tnoc_output_arbiter.sv
// tnoc_output_arbiter: packet-atomic N:1 output arbiter with a one-flit output register.
// An IDLE cycle picks a requester; BUSY forwards that port's flits until its tail is accepted.
// Optional build macro TNOC_OUTPUT_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest-index valid port wins.
module tnoc_output_arbiter #(
    parameter int FLIT_WIDTH = 64,
    parameter int PORTS      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            i_valid,
    input  logic [PORTS-1:0]            i_tail,
    input  logic [PORTS*FLIT_WIDTH-1:0] i_flit,
    output logic [PORTS-1:0]            o_ready,
    output logic                        o_valid,
    output logic                        o_tail,
    output logic [FLIT_WIDTH-1:0]       o_flit,
    input  logic                        i_ready,
    output logic [PORTS-1:0]            o_grant
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {StIdle, StBusy} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PORTS-1:0]      r_grant;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_valid;
    logic                  r_tail;
    logic [FLIT_WIDTH-1:0] r_flit;

    logic                  w_sel_found;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_can_accept;
    logic                  w_xfer;
    logic                  w_xfer_tail;
    logic [FLIT_WIDTH-1:0] w_in_flit;

    assign w_in_flit = i_flit[r_idx*FLIT_WIDTH +: FLIT_WIDTH];

`ifdef TNOC_OUTPUT_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;

    // Round-robin pick: first valid port scanning upward from the pointer, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % PORTS);
            if (!w_sel_found && i_valid[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    // Pointer moves past the owner once its tail has been accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer_tail) begin
            r_ptr <= (r_idx == IDX_W'(PORTS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end
`else
    // Fixed priority pick: lowest-index valid port.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!w_sel_found && i_valid[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // Next state and input-side handshake; only the owner is ever offered ready.
    always_comb begin
        w_state_next = r_state;
        w_can_accept = !r_valid || i_ready;
        o_ready      = '0;
        if (r_state == StBusy && w_can_accept) begin
            o_ready = r_grant;
        end
        w_xfer      = |(o_ready & i_valid);
        w_xfer_tail = w_xfer && i_tail[r_idx];
        unique case (r_state)
            StIdle:  if (w_sel_found) w_state_next = StBusy;
            StBusy:  if (w_xfer_tail) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register and grant ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && w_sel_found) begin
                r_grant <= PORTS'(1) << w_sel_idx;
                r_idx   <= w_sel_idx;
            end else if (w_xfer_tail) begin
                r_grant <= '0;
            end
        end
    end

    // Output register: load on accept, drain when downstream takes it, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tail  <= 1'b0;
            r_flit  <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_tail  <= i_tail[r_idx];
            r_flit  <= w_in_flit;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_tail  = r_tail;
    assign o_flit  = r_flit;
    assign o_grant = r_grant;

endmodule

// File: tb/tb_tnoc_output_arbiter.sv
// Bench for tnoc_output_arbiter: directed vector table, hand-written corner sequences and
// random traffic checked every cycle against a transaction-level arbiter model.
module tb_tnoc_output_arbiter;

    localparam int FW = 64;
    localparam int NP = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     i_valid;
    logic [NP-1:0]     i_tail;
    logic [NP*FW-1:0]  i_flit;
    logic [NP-1:0]     o_ready;
    logic              o_valid;
    logic              o_tail;
    logic [FW-1:0]     o_flit;
    logic              i_ready;
    logic [NP-1:0]     o_grant;

    always #5 clk = ~clk;

    tnoc_output_arbiter #(
        .FLIT_WIDTH (FW),
        .PORTS      (NP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_tail  (i_tail),
        .i_flit  (i_flit),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_tail  (o_tail),
        .o_flit  (o_flit),
        .i_ready (i_ready),
        .o_grant (o_grant)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sources: per-port flit queues, entry = {tail, flit}.
    logic [FW:0]   src_q[NP][$];
    logic [NP-1:0] held = '0;
    int            serial = 1;
    int            pkt_no = 0;

    task automatic add_pkt(int p, int len);
        for (int k = 0; k < len; k++) begin
            src_q[p].push_back({(k == len - 1), 8'(p), 8'(pkt_no), 32'h0, 16'(serial)});
            serial++;
        end
        pkt_no++;
    endtask

    // A presented but unaccepted flit is always kept; otherwise present only if allowed.
    task automatic drive(logic [NP-1:0] allow, logic rdy);
        logic [FW:0] e;
        i_valid = '0;
        i_tail  = '0;
        i_flit  = '0;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && (held[p] || allow[p])) begin
                e = src_q[p][0];
                i_valid[p]          = 1'b1;
                i_tail[p]           = e[FW];
                i_flit[p*FW +: FW]  = e[FW-1:0];
            end
        end
        i_ready = rdy;
    endtask

    // Reference model: who owns the output, and what sits in the one-deep output stage.
    logic          m_busy  = 1'b0;
    int            m_owner = 0;
    int            m_ptr   = 0;
    logic          m_ov    = 1'b0;
    logic [FW-1:0] m_flit  = '0;
    logic          m_tail  = 1'b0;
    logic          m_clean = 1'b1;

    function automatic int pick(logic [NP-1:0] v);
`ifdef TNOC_OUTPUT_ARBITER_ROUND_ROBIN_EN
        for (int i = 0; i < NP; i++) if (v[(m_ptr + i) % NP]) return (m_ptr + i) % NP;
`else
        for (int i = 0; i < NP; i++) if (v[i]) return i;
`endif
        return 0;
    endfunction

    // Downstream observer: packet atomicity and per-port ordering on the output link.
    int obs_cur = -1;
    int obs_ports[$];
    int last_s[NP];
    int obs_cnt[NP];

    task automatic observe(logic [FW-1:0] f, logic t);
        int p;
        int s;
        p = int'(f[63:56]);
        s = int'(f[15:0]);
        if (obs_cur >= 0) chk("atomic", p, obs_cur);
        else obs_ports.push_back(p);
        if (p < NP) begin
            chk("order", (s > last_s[p]), 1);
            last_s[p] = s;
            obs_cnt[p]++;
        end
        obs_cur = t ? -1 : p;
    endtask

    // Compare the DUT to the model, then advance both across one rising edge.
    task automatic edge_step();
        logic [NP-1:0] eg;
        logic [NP-1:0] er;
        logic          acc;
        logic          was_busy;
        logic          r;
        logic [FW-1:0] af;
        logic          at;
        logic [NP-1:0] v;
        eg = m_busy ? (NP'(1) << m_owner) : '0;
        er = (m_busy && (!m_ov || i_ready)) ? eg : '0;
        chk("o_grant", o_grant, eg);
        chk("o_ready", o_ready, er);
        chk("o_valid", o_valid, m_ov);
        if (m_ov || m_clean) begin
            chk("o_flit", o_flit, m_flit);
            chk("o_tail", o_tail, m_tail);
        end
        acc      = m_busy && i_valid[m_owner] && (!m_ov || i_ready);
        af       = i_flit[m_owner*FW +: FW];
        at       = i_tail[m_owner];
        was_busy = m_busy;
        r        = rst;
        v        = i_valid;
        if (!r && o_valid && i_ready) observe(o_flit, o_tail);
        @(posedge clk);
        if (r) begin
            m_busy  = 1'b0;
            m_ov    = 1'b0;
            m_flit  = '0;
            m_tail  = 1'b0;
            m_clean = 1'b1;
            m_ptr   = 0;
            obs_cur = -1;
            held    = v;
        end else begin
            for (int p = 0; p < NP; p++) held[p] = v[p] && !(acc && p == m_owner);
            if (acc) begin
                if (src_q[m_owner].size() > 0) void'(src_q[m_owner].pop_front());
                m_ov    = 1'b1;
                m_flit  = af;
                m_tail  = at;
                m_clean = 1'b0;
                if (at) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % NP;
                end
            end else if (i_ready) begin
                m_ov = 1'b0;
            end
            if (!was_busy && |v) begin
                m_owner = pick(v);
                m_busy  = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        #4;
        edge_step();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = '0;
        i_tail  = '0;
        i_flit  = '0;
        i_ready = 1'b1;
        cycle();
        cycle();
        rst     = 1'b0;
        held    = '0;
        obs_cur = -1;
        obs_ports.delete();
        for (int p = 0; p < NP; p++) begin
            last_s[p]  = -1;
            obs_cnt[p] = 0;
            src_q[p].delete();
        end
    endtask

    task automatic run_until_left(int p, int left, logic [NP-1:0] allow, int limit);
        int n = 0;
        while (src_q[p].size() > left && n < limit) begin
            drive(allow, 1'b1);
            cycle();
            n++;
        end
        chk("wait_left", src_q[p].size(), left);
    endtask

    task automatic drain_all(int limit);
        int n = 0;
        int tot;
        tot = 1;
        while (tot > 0 && n < limit) begin
            drive('1, 1'b1);
            cycle();
            n++;
            tot = 0;
            for (int p = 0; p < NP; p++) tot += src_q[p].size();
        end
        chk("drain", tot, 0);
        drive('0, 1'b1);
        cycle();
        cycle();
    endtask

    typedef struct {
        logic [NP-1:0] v;
        logic [NP-1:0] t;
        logic [FW-1:0] f;
        logic [NP-1:0] eg;
        logic [NP-1:0] er;
        logic          ev;
        logic [FW-1:0] ef;
        logic          et;
    } vec_t;

    function automatic vec_t mk(logic [NP-1:0] v, logic [NP-1:0] t, logic [FW-1:0] f,
                                logic [NP-1:0] eg, logic [NP-1:0] er, logic ev,
                                logic [FW-1:0] ef, logic et);
        vec_t x;
        x.v = v; x.t = t; x.f = f; x.eg = eg; x.er = er; x.ev = ev; x.ef = ef; x.et = et;
        return x;
    endfunction

    initial begin
        vec_t          tbl[6];
        int            exp_order[6];
        logic [FW-1:0] snap;

        rst     = 1'b1;
        i_valid = '0;
        i_tail  = '0;
        i_flit  = '0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_tail", o_tail, 0);
        chk("rst_o_flit", o_flit, 0);
        chk("rst_o_grant", o_grant, 0);
        chk("rst_o_ready", o_ready, 0);

        // Three-flit packet on port 2 with i_ready held high
        tbl[0] = mk(5'b00100, 5'b00000, 64'hA1, 5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0);
        tbl[1] = mk(5'b00100, 5'b00000, 64'hA1, 5'b00100, 5'b00100, 1'b0, 64'h0,  1'b0);
        tbl[2] = mk(5'b00100, 5'b00000, 64'hA2, 5'b00100, 5'b00100, 1'b1, 64'hA1, 1'b0);
        tbl[3] = mk(5'b00100, 5'b00100, 64'hA3, 5'b00100, 5'b00100, 1'b1, 64'hA2, 1'b0);
        tbl[4] = mk(5'b00000, 5'b00000, 64'h0,  5'b00000, 5'b00000, 1'b1, 64'hA3, 1'b1);
        tbl[5] = mk(5'b00000, 5'b00000, 64'h0,  5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0);
        for (int i = 0; i < 6; i++) begin
            i_valid           = tbl[i].v;
            i_tail            = tbl[i].t;
            i_flit            = '0;
            i_flit[2*FW +: FW] = tbl[i].f;
            i_ready           = 1'b1;
            #4;
            chk("tbl_grant", o_grant, tbl[i].eg);
            chk("tbl_ready", o_ready, tbl[i].er);
            chk("tbl_valid", o_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_flit", o_flit, tbl[i].ef);
                chk("tbl_tail", o_tail, tbl[i].et);
            end
            edge_step();
        end

        // All ports requesting single-flit packets
        do_reset();
        for (int k = 0; k < 6; k++) add_pkt(0, 1);
        for (int p = 1; p < NP; p++) add_pkt(p, 1);
`ifdef TNOC_OUTPUT_ARBITER_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 4, 0};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif
        drain_all(80);
        chk("arb_count", (obs_ports.size() >= 6), 1);
        if (obs_ports.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("arb_order", obs_ports[i], exp_order[i]);
        end

        // Port 3 requests first, port 1 must wait for the whole packet
        do_reset();
        add_pkt(3, 4);
        add_pkt(1, 4);
        drive(5'b01000, 1'b1);
        cycle();
        drain_all(40);
        chk("first_pkt_n", obs_ports.size(), 2);
        if (obs_ports.size() == 2) begin
            chk("first_pkt_p3", obs_ports[0], 3);
            chk("second_pkt_p1", obs_ports[1], 1);
        end

        // Downstream stall for three cycles mid-packet
        do_reset();
        add_pkt(0, 4);
        run_until_left(0, 2, '1, 20);
        snap = o_flit;
        for (int k = 0; k < 3; k++) begin
            drive('1, 1'b0);
            cycle();
            chk("stall_flit", o_flit, snap);
            chk("stall_valid", o_valid, 1);
            chk("stall_ready", o_ready[0], 0);
        end
        drain_all(20);
        chk("stall_count", obs_cnt[0], 4);

        // Reset mid-packet: packet discarded, pointer back to port 0
        do_reset();
        add_pkt(1, 4);
        run_until_left(1, 2, '1, 20);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        src_q[1].delete();
        held = '0;
        drive('0, 1'b1);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_grant", o_grant, 0);
        cycle();
        obs_ports.delete();
        add_pkt(0, 1);
        add_pkt(4, 1);
        drain_all(20);
        chk("post_rst_n", obs_ports.size(), 2);
        if (obs_ports.size() >= 1) chk("post_rst_first", obs_ports[0], 0);

        // Owner drops valid between flits while another port requests
        do_reset();
        add_pkt(2, 4);
        add_pkt(0, 2);
        run_until_left(2, 2, 5'b00100, 20);
        for (int k = 0; k < 2; k++) begin
            drive(5'b00001, 1'b1);
            cycle();
            chk("gap_grant", o_grant, 5'b00100);
        end
        drain_all(40);
        chk("gap_n", obs_ports.size(), 2);
        if (obs_ports.size() == 2) begin
            chk("gap_first", obs_ports[0], 2);
            chk("gap_second", obs_ports[1], 0);
        end
        chk("gap_p2_count", obs_cnt[2], 4);

        // Random traffic with stalls, bursty sources and occasional resets
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() < 3 && $urandom_range(0, 3) == 0) begin
                    add_pkt(p, int'($urandom_range(1, 4)));
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            drive(NP'($urandom), ($urandom_range(0, 3) != 0));
            cycle();
        end
        rst = 1'b0;
        drain_all(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tnoc_output_arbiter.md
TNOC_OUTPUT_ARBITER -- requirements
Module: tnoc_output_arbiter

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 64: width of one flit payload in bits.
REQ-002 SHALL have parameter PORTS, default 5: number of requesting input ports (local, x+, x-, y+, y-).
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  PORTS: per-port flit valid from the route selectors.
REQ-006 SHALL have port i_tail  input  PORTS: per-port flag, current flit is the last flit of its packet.
REQ-007 SHALL have port i_flit  input  PORTS*FLIT_WIDTH: per-port payload; port p occupies bits [p*FLIT_WIDTH +: FLIT_WIDTH].
REQ-008 SHALL have port o_ready  output  PORTS: per-port flit accept.
REQ-009 SHALL have port o_valid  output  1: output flit valid toward the output link.
REQ-010 SHALL have port o_tail  output  1: output flit is a tail.
REQ-011 SHALL have port o_flit  output  FLIT_WIDTH: output payload.
REQ-012 SHALL have port i_ready  input  1: downstream accept.
REQ-013 SHALL have port o_grant  output  PORTS: one-hot current owner, all-zero when idle.

Function
REQ-014 Transfer on a port SHALL occur when valid and ready are both high in the same cycle; valid without ready SHALL hold data stable (sources and this block alike).
REQ-015 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-016 IDLE: if any i_valid is high, SHALL select one requester (per REQ-026/027), set o_grant to it and enter BUSY next cycle; o_ready SHALL be all-zero in IDLE.
REQ-017 BUSY: o_ready SHALL be high only for the granted port, and only when the output register can accept (o_valid low or i_ready high); all other o_ready bits SHALL be low.
REQ-018 Output register: an accepted flit SHALL appear on o_valid/o_flit/o_tail exactly one cycle after acceptance; latency 1 cycle, throughput 1 flit/cycle with i_ready held high.
REQ-019 o_valid SHALL drop the cycle after the register drains (i_ready high) with no new flit accepted.
REQ-020 Acceptance of a flit with i_tail high SHALL return the FSM to IDLE on the next cycle and clear o_grant; the registered tail flit SHALL still be presented until accepted downstream.
REQ-021 Packet atomicity: flits of a packet SHALL never be interleaved with flits from another port on the output.
REQ-022 A single-flit packet (head is tail) SHALL occupy BUSY for exactly one accepting cycle.
REQ-023 Minimum gap between the tail of one packet and the head of the next SHALL be one idle arbitration cycle on the input side (no input handshake in the IDLE cycle).
REQ-024 i_valid dropping on the granted port mid-packet SHALL NOT release the grant; the FSM SHALL wait in BUSY.
REQ-025 i_ready low SHALL stall: output register held, granted o_ready low, FSM state unchanged.

Configuration
REQ-026 With macro TNOC_OUTPUT_ARBITER_ROUND_ROBIN_EN defined: round-robin; a pointer SHALL reset to port 0, search starts at pointer, and on tail acceptance pointer SHALL become (granted index + 1) modulo PORTS.
REQ-027 Without TNOC_OUTPUT_ARBITER_ROUND_ROBIN_EN: fixed priority, lowest-index valid port wins; no pointer register.

Reset
REQ-028 With rst high at a clock edge: FSM SHALL enter IDLE, o_valid=0, o_tail=0, o_flit=0, o_grant=0, o_ready=0, round-robin pointer=0.
REQ-029 Reset asserted mid-packet SHALL discard the packet and the registered flit; no partial flit SHALL appear after rst deasserts.
REQ-030 First grant after reset deassertion SHALL be possible no earlier than the first edge with rst low.

Verification
REQ-031 Single port 2 valid, 3-flit packet (0xA1,0xA2,0xA3 tail), i_ready=1 -> o_grant=5'b00100 one cycle after i_valid, o_flit sequence A1,A2,A3 on consecutive cycles, o_tail with A3.
REQ-032 All ports valid, 1-flit packets, round-robin enabled -> output order ports 0,1,2,3,4,0; fixed priority -> port 0 repeatedly while it stays valid.
REQ-033 Ports 1 and 3 valid with 4-flit packets, port 3 asserts first -> all 4 port-3 flits output before any port-1 flit.
REQ-034 i_ready low for 3 cycles mid-packet -> o_flit/o_valid stable, o_ready of granted port low for those cycles, no flit lost or duplicated.
REQ-035 rst pulsed after second flit of a 4-flit packet -> next cycle o_valid=0, o_grant=0, pointer=0; remaining flits not forwarded.
REQ-036 Granted port drops i_valid for 2 cycles mid-packet while another port requests -> grant unchanged, packet resumes intact.
